// File: rtl/pusch_cp_insert_if.sv
// Sample bus between the IFFT, the CP insertion stage and the radio side.
// slave = CP inserter; master = whoever drives IFFT samples and consumes the output.
interface pusch_cp_insert_if #(
  parameter int WIDTH = 26
);
  logic signed [WIDTH-1:0] Data_r;
  logic signed [WIDTH-1:0] Data_i;
  logic                    Data_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out_r;
  logic signed [WIDTH-1:0] out_i;
  logic                    out_valid;
  logic                    sym_start;
  logic                    slot_start;
  logic [3:0]              sym_idx;

  modport slave (
    input  Data_r, Data_i, Data_valid,
    output in_ready,
    output out_r, out_i, out_valid, sym_start, slot_start, sym_idx
  );

  modport master (
    output Data_r, Data_i, Data_valid,
    input  in_ready,
    input  out_r, out_i, out_valid, sym_start, slot_start, sym_idx
  );
endinterface

// File: rtl/pusch_cp_insert.sv
// Ping-pong buffered cyclic-prefix insertion: emits tail-copy CP then the full symbol.
// First output 2 cycles after a symbol completes from idle; input throttled by in_ready, output has no backpressure.
module pusch_cp_insert #(
  parameter int WIDTH        = 26,
  parameter int N_FFT        = 1024,
  parameter int CP_LEN       = 72,
  parameter int CP_EXT       = 8,
  parameter int SYM_PER_SLOT = 14
) (
  input  logic             clk,
  input  logic             reset,
  pusch_cp_insert_if.slave bus
);

  localparam int            AW          = $clog2(N_FFT);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(N_FFT - 1);
  localparam logic [AW-1:0] CP_SHORT_M1 = AW'(CP_LEN - 1);
  localparam logic [AW-1:0] CP_LONG_M1  = AW'(CP_LEN + CP_EXT - 1);
  localparam logic [3:0]    LAST_SYM    = 4'(SYM_PER_SLOT - 1);
  localparam logic [3:0]    MID_SYM     = 4'(SYM_PER_SLOT / 2);

  typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} rd_state_e;

  logic [2*WIDTH-1:0] ram [2*N_FFT];

  logic              wr_bank_q, wr_bank_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [1:0]        full_q, full_d;
  rd_state_e         state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [3:0]        sym_cnt_q, sym_cnt_d;

  logic [2*WIDTH-1:0] out_dat_q;
  logic               out_vld_q;
  logic               sym_start_q;
  logic               slot_start_q;
  logic [3:0]         sym_idx_q;

  logic          in_ready;
  logic          wr_fire;
  logic          wr_last;
  logic [AW-1:0] cp_len_m1;
  logic          rd_issue;
  logic          rd_first;
  logic          rd_release;
  logic [AW-1:0] rd_addr;

  assign in_ready  = ~full_q[wr_bank_q];
  assign wr_fire   = bus.Data_valid & in_ready;
  assign wr_last   = wr_fire && (wr_addr_q == LAST_ADDR);
  assign cp_len_m1 = (sym_cnt_q == 4'd0 || sym_cnt_q == MID_SYM) ? CP_LONG_M1 : CP_SHORT_M1;

  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    if (wr_fire) begin
      wr_addr_d = wr_addr_q + 1'b1;
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    sym_cnt_d  = sym_cnt_q;
    rd_issue   = 1'b0;
    rd_first   = 1'b0;
    rd_release = 1'b0;
    rd_addr    = '0;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = S_CP;
          rd_cnt_d = '0;
        end
      end
      S_CP: begin
        rd_issue = 1'b1;
        rd_first = (rd_cnt_q == '0);
        // N_FFT - cp_len + cnt, with N_FFT vanishing modulo 2^AW and -(m1+1) == ~m1
        rd_addr  = rd_cnt_q + ~cp_len_m1;
        if (rd_cnt_q == cp_len_m1) begin
          state_d  = S_BODY;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      S_BODY: begin
        rd_issue = 1'b1;
        rd_addr  = rd_cnt_q;
        if (rd_cnt_q == LAST_ADDR) begin
          rd_release = 1'b1;
          rd_bank_d  = ~rd_bank_q;
          rd_cnt_d   = '0;
          sym_cnt_d  = (sym_cnt_q == LAST_SYM) ? 4'd0 : sym_cnt_q + 4'd1;
          // the other bank may be completing on this very cycle
          if (full_q[~rd_bank_q] || (wr_last && (wr_bank_q != rd_bank_q))) state_d = S_CP;
          else                                                           state_d = S_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (wr_last)    full_d[wr_bank_q] = 1'b1;
    if (rd_release) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) ram[{wr_bank_q, wr_addr_q}] <= {bus.Data_r, bus.Data_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      full_q       <= '0;
      state_q      <= S_IDLE;
      rd_bank_q    <= 1'b0;
      rd_cnt_q     <= '0;
      sym_cnt_q    <= '0;
      out_dat_q    <= '0;
      out_vld_q    <= 1'b0;
      sym_start_q  <= 1'b0;
      slot_start_q <= 1'b0;
      sym_idx_q    <= '0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      full_q       <= full_d;
      state_q      <= state_d;
      rd_bank_q    <= rd_bank_d;
      rd_cnt_q     <= rd_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      out_dat_q    <= rd_issue ? ram[{rd_bank_q, rd_addr}] : '0;
      out_vld_q    <= rd_issue;
      sym_start_q  <= rd_first;
      slot_start_q <= rd_first && (sym_cnt_q == 4'd0);
      if (rd_issue) sym_idx_q <= sym_cnt_q;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_r      = out_dat_q[2*WIDTH-1:WIDTH];
  assign bus.out_i      = out_dat_q[WIDTH-1:0];
  assign bus.out_valid  = out_vld_q;
  assign bus.sym_start  = sym_start_q;
  assign bus.slot_start = slot_start_q;
  assign bus.sym_idx    = sym_idx_q;

endmodule

// File: tb/tb_pusch_cp_insert.sv
// Bench for pusch_cp_insert with a 16-point symbol, CP 4 (+1 on symbols 0 and 7).
// Expected output streams are rebuilt from the samples actually accepted at the input.
module tb_pusch_cp_insert;

  localparam int W = 26;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pusch_cp_insert_if #(.WIDTH(W)) bus ();

  pusch_cp_insert #(
    .WIDTH(W), .N_FFT(N), .CP_LEN(4), .CP_EXT(1), .SYM_PER_SLOT(14)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] i;
    logic         ss;
    logic         sl;
    logic [3:0]   idx;
  } out_t;

  typedef struct {
    string name;
    int    nsamp;
    int    gap;
    bit    blind;
    int    exp_outs;
    bit    exp_throttle;
  } row_t;

  logic [2*W-1:0] acc_q[$];
  out_t           obs_q[$];
  int             ocyc_q[$];
  int             first_done_cyc;
  int             nrdy_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: record accepted inputs and all valid outputs; reset clears the record.
  always @(negedge clk) begin
    if (reset) begin
      acc_q.delete();
      obs_q.delete();
      ocyc_q.delete();
      first_done_cyc = -1;
      nrdy_cnt       = 0;
    end else begin
      if (!bus.in_ready) nrdy_cnt++;
      if (bus.Data_valid && bus.in_ready) begin
        acc_q.push_back({bus.Data_r, bus.Data_i});
        if (acc_q.size() == N) first_done_cyc = cyc + 1;
      end
      if (bus.out_valid) begin
        obs_q.push_back({bus.out_r, bus.out_i, bus.sym_start, bus.slot_start, bus.sym_idx});
        ocyc_q.push_back(cyc);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.Data_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input int target, input int gap, input bit blind);
    int           acc = 0;
    int           v = 0;
    int           guard = 0;
    logic         took;
    logic [W-1:0] vr;
    while (acc < target && guard < 5000) begin
      for (int g = 0; g < gap; g++) begin
        bus.Data_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      vr = W'(v);
      bus.Data_r     = vr;
      bus.Data_i     = -vr;
      bus.Data_valid = 1'b1;
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        acc++;
        v++;
      end else if (blind) begin
        v++;
      end
      guard++;
    end
    bus.Data_valid = 1'b0;
    if (acc < target) check("drive_timeout", 64'(acc), 64'(target));
  endtask

  task automatic wait_outputs(input int exp_outs);
    for (int c = 0; c < 3000 && obs_q.size() < exp_outs; c++) @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string name, input int nsym, input int exp_outs,
                           input bit exp_throttle);
    int   idx = 0;
    int   cp;
    int   k;
    out_t e;
    out_t a;
    check({name, ".accepted"}, 64'(acc_q.size()), 64'(nsym * N));
    check({name, ".out_count"}, 64'(obs_q.size()), 64'(exp_outs));
    check({name, ".latency"},
          64'(obs_q.size() > 0 ? ocyc_q[0] - first_done_cyc : -1), 64'(2));
    check({name, ".gapfree_span"},
          64'(obs_q.size() > 0 ? ocyc_q[ocyc_q.size()-1] - ocyc_q[0] + 1 : 0), 64'(exp_outs));
    check({name, ".throttled"}, 64'(nrdy_cnt > 0), 64'(exp_throttle));
    for (int s = 0; s < nsym && s * N + N <= acc_q.size(); s++) begin
      cp = (s % 14 == 0 || s % 14 == 7) ? 5 : 4;
      for (int j = 0; j < cp + N; j++) begin
        k     = (j < cp) ? (N - cp + j) : (j - cp);
        e.r   = acc_q[s*N + k][2*W-1:W];
        e.i   = acc_q[s*N + k][W-1:0];
        e.ss  = (j == 0);
        e.sl  = (j == 0) && (s % 14 == 0);
        e.idx = 4'(s % 14);
        a     = (idx < obs_q.size()) ? obs_q[idx] : '1;
        check($sformatf("%s.sym%0d.out%0d", name, s, j), 64'(a), 64'(e));
        idx++;
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, ".out_valid"},  64'(bus.out_valid),  64'(0));
    check({name, ".out_r"},      64'(bus.out_r),      64'(0));
    check({name, ".out_i"},      64'(bus.out_i),      64'(0));
    check({name, ".sym_start"},  64'(bus.sym_start),  64'(0));
    check({name, ".slot_start"}, 64'(bus.slot_start), 64'(0));
    check({name, ".sym_idx"},    64'(bus.sym_idx),    64'(0));
    check({name, ".in_ready"},   64'(bus.in_ready),   64'(1));
  endtask

  row_t rows[5];

  initial begin
    rows[0] = '{"one_sym",     16,  0, 1'b0, 21,  1'b0};
    rows[1] = '{"three_sym",   48,  0, 1'b0, 61,  1'b1};
    rows[2] = '{"duty_1of3",   16,  2, 1'b0, 21,  1'b0};
    rows[3] = '{"slot_wrap",   240, 0, 1'b0, 303, 1'b1};
    rows[4] = '{"blind_valid", 48,  0, 1'b1, 61,  1'b1};

    bus.Data_r     = '0;
    bus.Data_i     = '0;
    bus.Data_valid = 1'b0;
    do_reset();
    check_idle_outputs("reset");

    for (int r = 0; r < 5; r++) begin
      do_reset();
      drive(rows[r].nsamp, rows[r].gap, rows[r].blind);
      wait_outputs(rows[r].exp_outs);
      check_run(rows[r].name, rows[r].nsamp / N, rows[r].exp_outs, rows[r].exp_throttle);
    end

    // Reset lands mid-way through symbol 2 while symbol 1 is being emitted.
    do_reset();
    drive(2 * N + 9, 0, 1'b0);
    check("midreset.pre_valid", 64'(bus.out_valid), 64'(1));
    #2 reset = 1'b1;
    #1 check_idle_outputs("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    drive(N, 0, 1'b0);
    wait_outputs(21);
    check_run("after_reset", 1, 21, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
